ram_arbiter: RTL and testbench

- Shares the single synchronous word RAM between the instruction-fetch port (read-only) and the data port (read/write) of the simulation CPU.
- Sequences every RAM access:
  - drives en/write_sel/addr/data_in;
  - holds address and write data one extra cycle for the RAM's delayed write commit;
  - returns read data to the requester that won arbitration.
- Sits between the core's fetch/memory stages and the RAM model in the sim top level.

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arb_pick.sv | 30 +++
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, port ownership and default bus widths.
package ram_arbiter_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;
    localparam int WE_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RESP  = 3'd2,
        S_WR    = 3'd3,
        S_WHOLD = 3'd4
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between fetch and data ports.
// RAM_ARBITER_RR_EN switches contention handling from DATA-first to round-robin.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic   i_fetch_req,
    input  logic   i_data_req,
`ifdef RAM_ARBITER_RR_EN
    input  owner_t i_last_grant,
`endif
    output logic   o_gnt_vld,
    output owner_t o_gnt
);

    always_comb begin
        o_gnt_vld = i_fetch_req | i_data_req;
        o_gnt     = OWN_INST;
        if (i_data_req && !i_fetch_req) begin
            o_gnt = OWN_DATA;
        end else if (i_data_req && i_fetch_req) begin
`ifdef RAM_ARBITER_RR_EN
            // On contention the port that did not win last time goes next.
            o_gnt = (i_last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
`else
            o_gnt = OWN_DATA;
`endif
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Sequences fetch and data accesses onto a single synchronous word RAM (3-cycle access incl. IDLE).
// Optional macro RAM_ARBITER_RR_EN: round-robin arbitration instead of fixed DATA priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int DATA_W = DATA_BUS
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [WE_W-1:0]   d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic [WE_W-1:0]   ram_write_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_t              r_state;
    owner_t              r_owner;
    logic                r_ram_en;
    logic [WE_W-1:0]     r_ram_sel;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_i_ready;
    logic                r_d_ready;

    state_t              w_state_nxt;
    owner_t              w_owner_nxt;
    logic                w_en_nxt;
    logic [WE_W-1:0]     w_sel_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_i_ready_nxt;
    logic                w_d_ready_nxt;
    logic                w_gnt_vld;
    owner_t              w_gnt;

`ifdef RAM_ARBITER_RR_EN
    owner_t              r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWN_INST;
        end else if (r_state == S_IDLE && w_gnt_vld) begin
            r_last_grant <= w_gnt;
        end
    end
`endif

    ram_arb_pick u_pick (
        .i_fetch_req  (i_req),
        .i_data_req   (d_req),
`ifdef RAM_ARBITER_RR_EN
        .i_last_grant (r_last_grant),
`endif
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt        (w_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_INST;
            r_ram_en    <= 1'b0;
            r_ram_sel   <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ram_en    <= w_en_nxt;
            r_ram_sel   <= w_sel_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_wdata <= w_wdata_nxt;
            r_i_ready   <= w_i_ready_nxt;
            r_d_ready   <= w_d_ready_nxt;
        end
    end

    // Address/wdata default to hold so the RAM's delayed write commit sees stable values.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_en_nxt      = 1'b0;
        w_sel_nxt     = '0;
        w_addr_nxt    = r_ram_addr;
        w_wdata_nxt   = r_ram_wdata;
        w_i_ready_nxt = 1'b0;
        w_d_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_owner_nxt = w_gnt;
                    w_en_nxt    = 1'b1;
                    if (w_gnt == OWN_DATA) begin
                        w_addr_nxt    = d_addr;
                        w_wdata_nxt   = d_wdata;
                        w_sel_nxt     = d_we;
                        w_d_ready_nxt = 1'b1;
                        w_state_nxt   = (d_we != '0) ? S_WR : S_RD;
                    end else begin
                        w_addr_nxt    = i_addr;
                        w_i_ready_nxt = 1'b1;
                        w_state_nxt   = S_RD;
                    end
                end
            end
            S_RD:    w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            S_WR:    w_state_nxt = S_WHOLD;
            S_WHOLD: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ram_en        = r_ram_en;
    assign ram_write_sel = r_ram_sel;
    assign ram_addr      = r_ram_addr;
    assign ram_wdata     = r_ram_wdata;
    assign i_ready       = r_i_ready;
    assign d_ready       = r_d_ready;
    assign busy          = (r_state != S_IDLE);

    // Read data is steered straight from the RAM output register during RESP.
    assign i_rvalid = (r_state == S_RESP) && (r_owner == OWN_INST);
    assign d_rvalid = (r_state == S_RESP) && (r_owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? ram_rdata : '0;
    assign d_rdata  = d_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, table-driven accesses, read-data scoreboard.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic [3:0]  ram_write_sel;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        busy;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_write_sel(ram_write_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // Behavioural RAM: registered read, byte-masked write committed one cycle after ram_en.
    logic [31:0] mem [0:63];
    logic [3:0]  pend_we = 4'h0;
    bit          mem_ready = 1'b0;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd64) return 32'h0;
        return mem[a[7:2]];
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'hA500_0000 | k;
            mem[4]    <= 32'hDEAD_BEEF;
            mem_ready <= 1'b1;
        end
        if (rst) begin
            pend_we <= 4'h0;
        end else begin
            if (pend_we != 4'h0 && ram_addr[1:0] == 2'b00 && ram_addr[31:2] < 30'd64)
                for (int b = 0; b < 4; b++)
                    if (pend_we[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            pend_we <= ram_en ? ram_write_sel : 4'h0;
            if (ram_en && ram_write_sel == 4'h0) ram_rdata <= ram_rd(ram_addr);
        end
    end

    typedef struct {
        logic        own;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        own;
        logic [31:0] data;
        logic [31:0] other;
    } obs_t;

    typedef struct {
        string       nm;
        bit          is_d;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Advance one clock and sample responses 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (i_rvalid) obs_q.push_back('{own: 1'b0, data: i_rdata, other: d_rdata});
        if (d_rvalid) obs_q.push_back('{own: 1'b1, data: d_rdata, other: i_rdata});
    endtask

    task automatic sb_check(input string nm);
        exp_t e;
        obs_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({nm, "_missing_rvalid"}, 32'h0, 32'h1);
            end else begin
                o = obs_q.pop_front();
                chk({nm, "_owner"}, {31'h0, o.own}, {31'h0, e.own});
                chk({nm, "_rdata"}, o.data, e.data);
                chk({nm, "_other_rdata"}, o.other, 32'h0);
            end
        end
        chk({nm, "_extra_rvalid"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic run_access(input string nm, input bit is_d, input logic [3:0] we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp);
        int n;
        int nb;
        bit got;
        bit is_wr;
        is_wr = is_d && (we != 4'h0);
        tick();
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        if (!is_wr) exp_q.push_back('{own: is_d, data: exp});
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = is_d ? d_ready : i_ready;
        end
        chk({nm, "_ready_lat"}, n, 1);
        i_req = 1'b0;
        d_req = 1'b0;
        chk({nm, "_en"}, {31'h0, ram_en}, 32'h1);
        chk({nm, "_sel"}, {28'h0, ram_write_sel}, is_wr ? {28'h0, we} : 32'h0);
        chk({nm, "_addr"}, ram_addr, addr);
        nb = 0;
        while (busy && nb < 10) begin
            nb++;
            if (nb == 2) begin
                chk({nm, "_ready_pulse"}, {30'h0, i_ready, d_ready}, 32'h0);
                if (is_wr) begin
                    chk({nm, "_whold_en_sel"}, {27'h0, ram_en, ram_write_sel}, 32'h0);
                    chk({nm, "_whold_addr"}, ram_addr, addr);
                    chk({nm, "_whold_wdata"}, ram_wdata, wdata);
                end else begin
                    chk({nm, "_rvalid_time"}, {31'h0, is_d ? d_rvalid : i_rvalid}, 32'h1);
                end
            end
            tick();
        end
        chk({nm, "_busy_cycles"}, nb, 2);
    endtask

    vec_t vecs[11];

    initial begin
        int          n;
        int          grants;
        logic [31:0] v;
        bit          got;

        vecs[0]  = '{"fetch10",   1'b0, 4'h0, 32'h10,   32'h0,         32'hDEAD_BEEF};
        vecs[1]  = '{"wr20",      1'b1, 4'hF, 32'h20,   32'h1234_5678, 32'h0};
        vecs[2]  = '{"rd20",      1'b1, 4'h0, 32'h20,   32'h0,         32'h1234_5678};
        vecs[3]  = '{"wrbyte20",  1'b1, 4'h1, 32'h20,   32'h0000_00AB, 32'h0};
        vecs[4]  = '{"rd20b",     1'b1, 4'h0, 32'h20,   32'h0,         32'h1234_56AB};
        vecs[5]  = '{"fetch20",   1'b0, 4'h0, 32'h20,   32'h0,         32'h1234_56AB};
        vecs[6]  = '{"wrhalf24",  1'b1, 4'hC, 32'h24,   32'hAABB_CCDD, 32'h0};
        vecs[7]  = '{"rd24",      1'b1, 4'h0, 32'h24,   32'h0,         32'hAABB_0009};
        vecs[8]  = '{"fetchmis",  1'b0, 4'h0, 32'h103,  32'h0,         32'h0};
        vecs[9]  = '{"rdoor",     1'b1, 4'h0, 32'h1000, 32'h0,         32'h0};
        vecs[10] = '{"wroor",     1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, 32'h0};

        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) tick();
        chk("reset_flags", {26'h0, i_ready, i_rvalid, d_ready, d_rvalid, ram_en, busy}, 32'h0);
        chk("reset_sel", {28'h0, ram_write_sel}, 32'h0);
        chk("reset_addr", ram_addr, 32'h0);
        chk("reset_wdata", ram_wdata, 32'h0);
        chk("reset_rdata", i_rdata | d_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Contention: both ports held for four grants.
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 4'h0; d_addr = 32'h40;
`ifdef RAM_ARBITER_RR_EN
        exp_q.push_back('{own: 1'b1, data: 32'hA500_0010});
        exp_q.push_back('{own: 1'b0, data: 32'hDEAD_BEEF});
        exp_q.push_back('{own: 1'b1, data: 32'hA500_0010});
        exp_q.push_back('{own: 1'b0, data: 32'hDEAD_BEEF});
`else
        repeat (4) exp_q.push_back('{own: 1'b1, data: 32'hA500_0010});
`endif
        grants = 0;
        n = 0;
        while (grants < 4 && n < 40) begin
            tick();
            n++;
            if (i_ready && d_ready) chk("cont_double_ready", 32'h1, 32'h0);
            if (i_ready || d_ready) grants++;
        end
        chk("cont_grants", grants, 4);
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) tick();
        sb_check("cont");

        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].nm, vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
            sb_check(vecs[i].nm);
        end

        // Reset in RD: access dropped, no rvalid afterwards.
        tick();
        i_req = 1'b1; i_addr = 32'h10;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = i_ready;
        end
        chk("rstrd_ready_lat", n, 1);
        i_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstrd_flags", {26'h0, i_ready, i_rvalid, d_ready, d_rvalid, ram_en, busy}, 32'h0);
        chk("rstrd_addr", ram_addr, 32'h0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("rstrd_no_rvalid", obs_q.size(), 0);
        obs_q.delete();
        run_access("rstrd_next", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        sb_check("rstrd_next");

        // Reset in WHOLD: word either untouched or fully written.
        tick();
        d_req = 1'b1; d_we = 4'hF; d_addr = 32'h28; d_wdata = 32'h5566_7788;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = d_ready;
        end
        chk("rstwh_ready_lat", n, 1);
        d_req = 1'b0;
        tick();
        chk("rstwh_in_whold", {27'h0, busy, ram_write_sel}, 32'h10);
        #2 rst = 1'b1;
        #1;
        chk("rstwh_busy", {31'h0, busy}, 32'h0);
        chk("rstwh_ram_out", {27'h0, ram_en, ram_write_sel} | ram_addr | ram_wdata, 32'h0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        v = mem[10];
        total++;
        if (v !== 32'hA500_000A && v !== 32'h5566_7788) begin
            bad++;
            $display("FAIL rstwh_word: got %h want a500000a or 55667788", v);
        end
        run_access("rstwh_rd", 1'b1, 4'h0, 32'h28, 32'h0, v);
        sb_check("rstwh_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
